// File: rtl/fp_result_queue.sv
// Result collector for the fixed-latency FP add/sub pipeline: in-order FIFO,
// valid/ready dequeue, and issue credits that keep in-flight results from overflowing.
module fp_result_queue #(
  parameter int LATENCY = 14,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         issue_req,
  output logic                         issue_grant,
  input  logic                         fp_done,
  input  logic [WIDTH-1:0]             fp_result,
  output logic                         deq_valid,
  output logic [WIDTH-1:0]             deq_data,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [0:0] {
    ST_DRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [LW-1:0]    drain_cnt_r;
  logic [LW-1:0]    drain_cnt_nxt_s;
  logic [CW-1:0]    credits_r;
  logic [CW-1:0]    credits_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             overflow_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             grant_s;
  logic             deq_fire_s;
  logic             enq_try_s;
  logic             enq_ok_s;

  // Handshake decode; a full FIFO still accepts a result if the head leaves this cycle.
  always_comb begin
    grant_s    = (state_r == ST_RUN) && issue_req && (credits_r != {CW{1'b0}});
    deq_fire_s = (count_r != {CW{1'b0}}) && deq_ready;
    enq_try_s  = (state_r == ST_RUN) && fp_done;
    enq_ok_s   = enq_try_s && ((count_r != CW'(DEPTH)) || deq_fire_s);
  end

  // Drain sequencer: stale done pulses from the unreset FP pipeline are ignored until RUN.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      ST_DRAIN: begin
        if (drain_cnt_r == LW'(1'b1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - LW'(1'b1);
        end
      end
      ST_RUN:   state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_DRAIN;
    endcase
  end

  // Credit and occupancy next values; simultaneous up/down cancel.
  always_comb begin
    credits_nxt_s = credits_r;
    count_nxt_s   = count_r;
    case ({grant_s, deq_fire_s})
      2'b10:   credits_nxt_s = credits_r - CW'(1'b1);
      2'b01:   credits_nxt_s = credits_r + CW'(1'b1);
      default: credits_nxt_s = credits_r;
    endcase
    case ({enq_ok_s, deq_fire_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_DRAIN;
      drain_cnt_r <= LW'(LATENCY);
      credits_r   <= CW'(DEPTH);
      count_r     <= {CW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      credits_r   <= credits_nxt_s;
      count_r     <= count_nxt_s;
      if (enq_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (deq_fire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      if (enq_try_s && !enq_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Result storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clock) begin
    if (enq_ok_s) begin
      mem_r[wr_ptr_r] <= fp_result;
    end
  end

  assign issue_grant = grant_s;
  assign deq_valid   = (count_r != {CW{1'b0}});
  assign deq_data    = mem_r[rd_ptr_r];
  assign credits     = credits_r;
  assign overflow    = overflow_r;

endmodule
